pipelined_barrel_shifter: RTL

//  Multi-mode barrel shifter for WIDTH-bit operands: logical left, logical right, arithmetic right, rotate left.

---
 rtl/shifter_pkg.sv | 26 ++
 rtl/shift_stage.sv | 77 +++++++
 rtl/pipelined_barrel_shifter.sv | 66 ++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

  // Per-operation shift mode; encoding matches the in_mode port.
  typedef enum logic [1:0] {
    SM_SLL = 2'b00,
    SM_SRL = 2'b01,
    SM_SRA = 2'b10,
    SM_ROL = 2'b11
  } shift_mode_t;

  // Ceiling log2, usable in constant expressions (log2(1) = 0).
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditional mode-aware shift by DIST, then a holdable register.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LOG_W = 3,
  parameter int DIST  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [LOG_W-1:0]  in_amt,
  input  shift_mode_t       in_mode,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [LOG_W-1:0]  out_amt,
  output shift_mode_t       out_mode
);

  // Amount bit that enables this stage's shift.
  localparam int AMT_BIT = log2(DIST);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [LOG_W-1:0] amt;
    shift_mode_t      mode;
  } stage_rec_t;

  stage_rec_t       stage_q;
  stage_rec_t       stage_d;
  logic [WIDTH-1:0] shifted_s;

  // Shift the incoming operand by DIST according to its own mode.
  // SRA keeps the MSB, which is the operand MSB captured at input since
  // every earlier stage also preserved it.
  always_comb begin
    shifted_s = in_data;
    case (in_mode)
      SM_SLL:  shifted_s = in_data << DIST;
      SM_SRL:  shifted_s = in_data >> DIST;
      SM_SRA:  shifted_s = $signed(in_data) >>> DIST;
      SM_ROL:  shifted_s = (in_data << DIST) | (in_data >> (WIDTH - DIST));
      default: shifted_s = in_data;
    endcase
  end

  // Next stage record: load when the pipe advances, otherwise hold.
  always_comb begin
    stage_d = stage_q;
    if (adv) begin
      stage_d.valid = in_valid;
      stage_d.data  = in_amt[AMT_BIT] ? shifted_s : in_data;
      stage_d.amt   = in_amt;
      stage_d.mode  = in_mode;
    end else begin
      stage_d = stage_q;
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q.valid;
  assign out_data  = stage_q.data;
  assign out_amt   = stage_q.amt;
  assign out_mode  = stage_q.mode;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode barrel shifter, one register per power-of-two shift stage,
// with valid/ready handshakes on both sides. Whole pipe stalls together.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LOG_W = log2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             adv_s;
  logic             valid_s [LOG_W+1];
  logic [WIDTH-1:0] data_s  [LOG_W+1];
  logic [LOG_W-1:0] amt_s   [LOG_W+1];
  shift_mode_t      mode_s  [LOG_W+1];
  logic             unused_s;

  // Pipe advances unless the final result is waiting on downstream;
  // nothing is accepted while reset is held.
  always_comb begin
    adv_s    = !out_valid || out_ready;
    in_ready = rst_n && adv_s;
  end

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign amt_s[0]   = in_amt;
  assign mode_s[0]  = shift_mode_t'(in_mode);

  for (genvar i = 0; i < LOG_W; i++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .LOG_W (LOG_W),
      .DIST  (32'sd1 <<< i)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv_s),
      .in_valid  (valid_s[i]),
      .in_data   (data_s[i]),
      .in_amt    (amt_s[i]),
      .in_mode   (mode_s[i]),
      .out_valid (valid_s[i+1]),
      .out_data  (data_s[i+1]),
      .out_amt   (amt_s[i+1]),
      .out_mode  (mode_s[i+1])
    );
  end

  assign out_valid = valid_s[LOG_W];
  assign out_data  = data_s[LOG_W];

  // Amount and mode are not needed past the last stage.
  assign unused_s = ^{amt_s[LOG_W], mode_s[LOG_W]};

endmodule
